// File: rtl/counter_prog.sv
// rtl/counter_prog.sv - programmable up/down event counter with prescaler, limit and flags
//
// Purpose: WIDTH-bit up/down counter over the range [0, limit] with a
//   runtime limit, wrap or saturate policy at the boundaries, synchronous
//   load, an enable prescaler, a terminal-count pulse and a sticky
//   boundary flag. Every output is registered.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-low
//   enable     count enable, feeds the prescaler
//   sel        direction, 0 = up, 1 = down
//   load       synchronous load strobe (wins over counting)
//   load_val   value loaded when load=1, taken as-is even above limit
//   limit      inclusive upper bound of the count range
//   clr_flags  clears ovf unless a boundary event happens in the same cycle
//   out        current count
//   tc         one-cycle pulse alongside each boundary-event result
//   ovf        sticky boundary-event flag
module counter_prog #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sel,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  // Prescaler needs at least one bit even when PRESCALE=1; in that case it
  // simply stays at 0 and every enabled cycle is a step.
  localparam int unsigned   PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RVAL = WIDTH'(RESET_VAL);

  logic [PW-1:0]    p;
  logic             step;
  logic             event_hit;
  logic [WIDTH-1:0] next_out;

  // Candidate result of a step; only committed when step is true.
  always_comb begin
    step      = enable && (p == PMAX);
    event_hit = 1'b0;
    next_out  = out;
    if (!sel) begin
      // >= rather than == so a count stranded above a lowered limit is
      // pulled back into range on the next up step.
      if (out >= limit) begin
        event_hit = 1'b1;
        next_out  = (SATURATE != 0) ? limit : '0;
      end else begin
        next_out = out + 1'b1;
      end
    end else begin
      if (out == '0) begin
        event_hit = 1'b1;
        next_out  = (SATURATE != 0) ? '0 : limit;
      end else begin
        next_out = out - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= RVAL;
      p   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      out <= load_val;
      p   <= '0;
      tc  <= 1'b0;
      if (clr_flags) begin
        ovf <= 1'b0;
      end
    end else begin
      if (enable) begin
        p <= step ? '0 : p + 1'b1;
      end
      if (step) begin
        out <= next_out;
      end
      tc <= step && event_hit;
      // A boundary event in the same cycle beats the clear request.
      if (step && event_hit) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_prog.sv
// tb/tb_counter_prog.sv - self-checking bench for counter_prog (wrap, saturate, prescale instances)
module tb_counter_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       sel = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] limit = 4'd9;
  logic       clr_flags = 1'b0;

  logic [3:0] dout [3];
  logic       dtc  [3];
  logic       dovf [3];

  // Instance 0: plain wrap, instance 1: saturate, instance 2: prescale by 3.
  counter_prog #(.WIDTH(4), .PRESCALE(1), .SATURATE(0), .RESET_VAL(0)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .sel(sel), .load(load),
    .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
    .out(dout[0]), .tc(dtc[0]), .ovf(dovf[0]));

  counter_prog #(.WIDTH(4), .PRESCALE(1), .SATURATE(1), .RESET_VAL(0)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .sel(sel), .load(load),
    .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
    .out(dout[1]), .tc(dtc[1]), .ovf(dovf[1]));

  counter_prog #(.WIDTH(4), .PRESCALE(3), .SATURATE(0), .RESET_VAL(0)) dut_p (
    .clk(clk), .rst(rst), .enable(enable), .sel(sel), .load(load),
    .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
    .out(dout[2]), .tc(dtc[2]), .ovf(dovf[2]));

  int errors = 0;
  int checks = 0;

  // Reference model: counts enabled cycles since the last reset/load and
  // steps whenever that count reaches a multiple of the prescale factor.
  int pre_f [3] = '{1, 1, 3};
  int sat_f [3] = '{0, 1, 0};
  int m_out [3];
  int m_cnt [3];
  int m_tc  [3];
  int m_ovf [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int ev;
      ev = 0;
      if (!rst) begin
        m_out[i] = 0; m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_out[i] = int'(load_val); m_cnt[i] = 0; m_tc[i] = 0;
        if (clr_flags) m_ovf[i] = 0;
      end else begin
        if (enable) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] % pre_f[i] == 0) begin
            if (!sel) begin
              if (m_out[i] < int'(limit)) m_out[i] = (m_out[i] + 1) % 16;
              else begin ev = 1; m_out[i] = sat_f[i] ? int'(limit) : 0; end
            end else begin
              if (m_out[i] > 0) m_out[i] = m_out[i] - 1;
              else begin ev = 1; m_out[i] = sat_f[i] ? 0 : int'(limit); end
            end
          end
        end
        m_tc[i] = ev;
        if (ev) m_ovf[i] = 1;
        else if (clr_flags) m_ovf[i] = 0;
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_out[%0d]", i), int'(dout[i]), m_out[i]);
      chk($sformatf("model_tc[%0d]", i),  int'(dtc[i]),  m_tc[i]);
      chk($sformatf("model_ovf[%0d]", i), int'(dovf[i]), m_ovf[i]);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1ns later.
  task automatic apply(input logic r, input logic en, input logic s, input logic ld,
                       input logic [3:0] lv, input logic [3:0] lim, input logic clr);
    rst = r; enable = en; sel = s; load = ld; load_val = lv; limit = lim; clr_flags = clr;
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  typedef struct {
    logic       r, en, s, ld;
    logic [3:0] lv, lim;
    logic       clr;
    int         eo, etc, eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic en, input logic s, input logic ld,
                              input logic [3:0] lv, input logic [3:0] lim, input logic clr,
                              input int eo, input int etc, input int eovf);
    vec_t v;
    v.r = r; v.en = en; v.s = s; v.ld = ld; v.lv = lv; v.lim = lim; v.clr = clr;
    v.eo = eo; v.etc = etc; v.eovf = eovf;
    return v;
  endfunction

  initial begin
    // Expected values below refer to the wrap instance (dut_w).
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 9, 0, 1, 0, 0));
    for (int k = 2; k <= 9; k++) vecs.push_back(mk(1, 1, 0, 0, 0, 9, 0, k, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 9, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 9, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0));
    // down wrap with an enable gap
    vecs.push_back(mk(1, 0, 1, 1, 2, 15, 0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 15, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 1, 0, 0, 15, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 15, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 15, 0, 15, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 15, 0, 14, 0, 1));
    // load beats enable; event beats clr_flags
    vecs.push_back(mk(1, 1, 0, 1, 7, 15, 0, 7, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 7, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0));
    // lowered limit below the current count
    vecs.push_back(mk(1, 0, 0, 1, 9, 15, 0, 9, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4, 0, 0, 1, 1));
    // limit = 0: every step is a boundary event
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    // down step above the limit, clr during load
    vecs.push_back(mk(1, 0, 1, 1, 12, 15, 1, 12, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5, 0, 11, 0, 0));
    // full-range natural roll-over
    vecs.push_back(mk(1, 0, 0, 1, 14, 15, 0, 14, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 15, 0, 15, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 15, 0, 0, 1, 1));
    // reset mid-operation leaves no residue
    vecs.push_back(mk(0, 1, 0, 0, 0, 15, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 15, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].en, vecs[i].s, vecs[i].ld, vecs[i].lv, vecs[i].lim, vecs[i].clr);
      chk($sformatf("vec%0d_out", i), int'(dout[0]), vecs[i].eo);
      chk($sformatf("vec%0d_tc", i),  int'(dtc[0]),  vecs[i].etc);
      chk($sformatf("vec%0d_ovf", i), int'(dovf[0]), vecs[i].eovf);
    end

    // Saturate: from 10 with limit 12 -> 11, 12, 12, 12; tc on held 12s.
    begin
      int exp_o [4] = '{11, 12, 12, 12};
      int exp_t [4] = '{0, 0, 1, 1};
      apply(1, 0, 0, 1, 10, 12, 0);
      for (int k = 0; k < 4; k++) begin
        apply(1, 1, 0, 0, 0, 12, 0);
        chk($sformatf("sat_out%0d", k), int'(dout[1]), exp_o[k]);
        chk($sformatf("sat_tc%0d", k),  int'(dtc[1]),  exp_t[k]);
      end
      apply(1, 1, 1, 0, 0, 12, 0);
      chk("sat_down_out", int'(dout[1]), 11);
      chk("sat_down_tc",  int'(dtc[1]),  0);
      apply(1, 0, 0, 1, 9, 15, 0);
      apply(1, 1, 0, 0, 0, 4, 0);
      chk("sat_clamp_out", int'(dout[1]), 4);
      chk("sat_clamp_tc",  int'(dtc[1]),  1);
    end

    // Prescale by 3, with an enable gap after two enabled cycles.
    begin
      int exp_o [3] = '{0, 0, 1};
      apply(1, 0, 0, 1, 0, 15, 0);
      for (int k = 0; k < 3; k++) begin
        apply(1, 1, 0, 0, 0, 15, 0);
        chk($sformatf("pre_out%0d", k), int'(dout[2]), exp_o[k]);
      end
      apply(1, 1, 0, 0, 0, 15, 0);
      apply(1, 1, 0, 0, 0, 15, 0);
      chk("pre_mid_out", int'(dout[2]), 1);
      for (int k = 0; k < 5; k++) apply(1, 0, 0, 0, 0, 15, 0);
      chk("pre_gap_out", int'(dout[2]), 1);
      apply(1, 1, 0, 0, 0, 15, 0);
      chk("pre_resume_out", int'(dout[2]), 2);
    end

    // Randomized traffic against the model on all three instances.
    for (int n = 0; n < 600; n++) begin
      logic       r, en, s, ld, clr;
      logic [3:0] lv, lim;
      r   = ($urandom_range(0, 31) != 0);
      en  = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 2) == 0) ? ~sel : sel;
      ld  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 7) == 0);
      lv  = 4'($urandom_range(0, 15));
      lim = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : limit;
      apply(r, en, s, ld, lv, lim, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
